// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and types for the RAM port arbiter slice (RAM geometry,
// port identifiers, counter sizing helper).
package ram_port_arbiter_pkg;

    localparam int RAM_DEPTH  = 512;
    localparam int RAM_ADDR_W = $clog2(RAM_DEPTH);
    localparam int RAM_DATA_W = 32;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Width needed to hold the values 0..max_burst inclusive.
    function automatic int burst_cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant decision for the RAM port arbiter.
// RAM_ARB_RR_EN selects strict round robin; otherwise fixed priority with anti-starvation.
module ram_arb_pick
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = burst_cnt_width(MAX_BURST)
) (
    input  logic             req0,
    input  logic             req1,
    input  logic [CNT_W-1:0] burst_cnt,
    input  port_e            last_gnt,
    output logic             pick0,
    output logic             pick1
);

`ifdef RAM_ARB_RR_EN
    logic [CNT_W-1:0] unused_burst_cnt;
    assign unused_burst_cnt = burst_cnt;

    // On contention the port that did not win last time goes next.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (req0 && req1) begin
            pick0 = (last_gnt == PORT1);
            pick1 = (last_gnt == PORT0);
        end else begin
            pick0 = req0;
            pick1 = req1;
        end
    end
`else
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    port_e unused_last_gnt;
    logic  starve;

    assign unused_last_gnt = last_gnt;
    assign starve          = (burst_cnt == BURST_LIMIT);

    // Port 0 wins contention until port 1 has watched MAX_BURST port-0 grants.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (req0 && req1) begin
            pick0 = ~starve;
            pick1 = starve;
        end else begin
            pick0 = req0;
            pick1 = req1;
        end
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of the single-port 512x32 RAM; one access per cycle,
// read return tagged to its issuer. Define RAM_ARB_RR_EN for round-robin arbitration.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = burst_cnt_width(MAX_BURST);

    logic             pick0;
    logic             pick1;
    logic [CNT_W-1:0] burst_cnt;
    port_e            last_gnt;

    ram_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .req0      (req0),
        .req1      (req1),
        .burst_cnt (burst_cnt),
        .last_gnt  (last_gnt),
        .pick0     (pick0),
        .pick1     (pick1)
    );

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign gnt0 = pick0 & reset_n;
    assign gnt1 = pick1 & reset_n;

    // With no grant the address/data buses park on port 0's fields.
    always_comb begin
        ram_addr  = addr0;
        ram_wdata = wdata0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        if (gnt1) begin
            ram_addr  = addr1;
            ram_wdata = wdata1;
            ram_read  = ~we1;
            ram_write = we1;
        end else if (gnt0) begin
            ram_read  = ~we0;
            ram_write = we0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    assign rdata = ram_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= PORT1;
        end else if (gnt0) begin
            last_gnt <= PORT0;
        end else if (gnt1) begin
            last_gnt <= PORT1;
        end
    end

`ifdef RAM_ARB_RR_EN
    assign burst_cnt = '0;
`else
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    // Counts port-0 wins while port 1 is waiting; saturates at the limit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt <= '0;
        end else if (gnt1 || !req1) begin
            burst_cnt <= '0;
        end else if (gnt0 && (burst_cnt != BURST_LIMIT)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM fixture, reference model
// and per-cycle comparison, plus directed scenarios with literal expectations.
module tb_ram_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          req0    = 1'b0;
    logic          we0     = 1'b0;
    logic [AW-1:0] addr0   = '0;
    logic [DW-1:0] wdata0  = '0;
    logic          req1    = 1'b0;
    logic          we1     = 1'b0;
    logic [AW-1:0] addr1   = '0;
    logic [DW-1:0] wdata1  = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_read, ram_write;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clock = ~clock;

    // RAM fixture: registered read, write at the edge.
    logic [DW-1:0] ram_mem [512];
    initial for (int i = 0; i < 512; i++) ram_mem[i] = 32'hC0DE0000 + i;
    always @(posedge clock) begin
        if (ram_read) ram_rdata <= ram_mem[ram_addr];
        if (ram_write) ram_mem[ram_addr] = ram_wdata;
    end

    // Reference model state.
    logic [DW-1:0] shadow [512];
    initial for (int i = 0; i < 512; i++) shadow[i] = 32'hC0DE0000 + i;
    bit            m_rv0    = 1'b0;
    bit            m_rv1    = 1'b0;
    logic [DW-1:0] m_rdata  = '0;
    int            m_streak = 0;
    int            m_last   = 1;

    function automatic int model_winner();
        if (!reset_n) return -1;
        if (req0 && !req1) return 0;
        if (req1 && !req0) return 1;
        if (!req0) return -1;
`ifdef RAM_ARB_RR_EN
        return (m_last == 0) ? 1 : 0;
`else
        return (m_streak >= MB) ? 1 : 0;
`endif
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int w;
        if (!reset_n) begin
            m_rv0    = 1'b0;
            m_rv1    = 1'b0;
            m_streak = 0;
            m_last   = 1;
        end else begin
            w     = model_winner();
            m_rv0 = 1'b0;
            m_rv1 = 1'b0;
            if (w == 0) begin
                if (we0) shadow[addr0] = wdata0;
                else begin m_rv0 = 1'b1; m_rdata = shadow[addr0]; end
            end else if (w == 1) begin
                if (we1) shadow[addr1] = wdata1;
                else begin m_rv1 = 1'b1; m_rdata = shadow[addr1]; end
            end
            if (w == 1 || !req1) m_streak = 0;
            else if (w == 0) m_streak = (m_streak < MB) ? m_streak + 1 : MB;
            if (w >= 0) m_last = w;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        int w;
        w = model_winner();
        check_output("gnt0", 32'(gnt0), 32'(w == 0));
        check_output("gnt1", 32'(gnt1), 32'(w == 1));
        check_output("ram_read", 32'(ram_read),
                     32'((w == 0 && !we0) || (w == 1 && !we1)));
        check_output("ram_write", 32'(ram_write),
                     32'((w == 0 && we0) || (w == 1 && we1)));
        if (reset_n) begin
            check_output("ram_addr", 32'(ram_addr), (w == 1) ? 32'(addr1) : 32'(addr0));
            check_output("ram_wdata", ram_wdata, (w == 1) ? wdata1 : wdata0);
        end
        check_output("rvalid0", 32'(rvalid0), 32'(m_rv0));
        check_output("rvalid1", 32'(rvalid1), 32'(m_rv1));
        if (m_rv0 || m_rv1) check_output("rdata", rdata, m_rdata);
    end

    task automatic apply_stimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                  input logic [DW-1:0] d0, input logic r1, input logic w1,
                                  input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(posedge clock);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

`ifdef RAM_ARB_RR_EN
    int exp3 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int exp4 [6]  = '{0, 1, 0, 1, 0, 1};
`else
    int exp3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp4 [6]  = '{0, 0, 0, 0, 1, 0};
`endif

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Write then read back the same address on port 0.
        apply_stimulus(1'b1, 1'b1, 9'h047, 32'h94, 1'b0, 1'b0, '0, '0);
        @(negedge clock) check_output("t1_wr_gnt0", 32'(gnt0), 32'd1);
        apply_stimulus(1'b1, 1'b0, 9'h047, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clock) check_output("t1_rd_gnt0", 32'(gnt0), 32'd1);
        apply_idle();
        @(negedge clock);
        check_output("t1_rvalid0", 32'(rvalid0), 32'd1);
        check_output("t1_rdata", rdata, 32'h94);

        // Port 1 streams four reads.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'(i), '0);
            else apply_idle();
            @(negedge clock);
            if (i < 4) check_output("t2_gnt1", 32'(gnt1), 32'd1);
            if (i > 0) begin
                check_output("t2_rvalid1", 32'(rvalid1), 32'd1);
                check_output("t2_rdata", rdata, 32'hC0DE0000 + 32'(i - 1));
            end
        end

        // Both ports held busy for ten cycles.
        apply_idle();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h020, '0);
            @(negedge clock);
            check_output("t3_grant", {30'b0, gnt1, gnt0}, (exp3[i] == 1) ? 32'd2 : 32'd1);
        end

        // Contention immediately after reset.
        apply_idle();
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'b0, 9'h011, '0, 1'b1, 1'b0, 9'h021, '0);
            @(negedge clock);
            check_output("t4_grant", {30'b0, gnt1, gnt0}, (exp4[i] == 1) ? 32'd2 : 32'd1);
        end

        // Same-address collision: the loser sees the winner's write.
        apply_idle();
        apply_stimulus(1'b1, 1'b1, 9'h005, 32'hABBA, 1'b1, 1'b0, 9'h005, '0);
        @(negedge clock);
        check_output("t5_gnt0", 32'(gnt0), 32'd1);
        check_output("t5_gnt1_wait", 32'(gnt1), 32'd0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h005, '0);
        @(negedge clock) check_output("t5_gnt1", 32'(gnt1), 32'd1);
        apply_idle();
        @(negedge clock);
        check_output("t5_rvalid1", 32'(rvalid1), 32'd1);
        check_output("t5_rdata", rdata, 32'hABBA);

        // Reset arriving while a read is in flight.
        apply_stimulus(1'b1, 1'b0, 9'h047, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clock) check_output("t6_gnt0", 32'(gnt0), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h030;
        @(negedge clock);
        check_output("t6_rvalid0_drop", 32'(rvalid0), 32'd0);
        check_output("t6_gnt_in_reset", {30'b0, gnt1, gnt0}, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_output("t6_first_gnt0", {30'b0, gnt1, gnt0}, 32'd1);
        check_output("t6_rvalid0_after", 32'(rvalid0), 32'd0);
        check_output("t6_rvalid1_after", 32'(rvalid1), 32'd0);
        apply_idle();
        repeat (3) @(posedge clock);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
